pipe_ctrl: RTL

//  Parametrised pipeline hold/flush controller; successor to the fixed-source ctrl block.

---
 rtl/pipe_ctrl_pkg.sv | 15 +
 rtl/pipe_ctrl_hold_arb.sv | 25 ++
 rtl/pipe_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - hold level encodings and halt FSM states for pipe_ctrl
package pipe_ctrl_pkg;

  localparam int HOLD_NONE = 0;
  localparam int HOLD_PC   = 1;
  localparam int HOLD_IF   = 2;
  localparam int HOLD_ID   = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_ctrl_hold_arb.sv
// rtl/pipe_ctrl_hold_arb.sv - combinational max-level reduction over NUM_REQ hold sources
module pipe_ctrl_hold_arb #(
  parameter int NUM_REQ = 4,
  parameter int HOLD_W  = 3
) (
  input  logic [HOLD_W-1:0]         i_base,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*HOLD_W-1:0] i_lvl,
  output logic [HOLD_W-1:0]         o_lvl
);

  logic [HOLD_W-1:0] w_max;

  // Pure numeric max: equal levels need no tie-break, source index carries no priority.
  always_comb begin
    w_max = i_base;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (i_req[k] && (i_lvl[k*HOLD_W +: HOLD_W] > w_max))
        w_max = i_lvl[k*HOLD_W +: HOLD_W];
    end
  end

  assign o_lvl = w_max;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hold/flush controller with debug-halt drain handshake
// Optional PIPE_CTRL_PERF_EN builds the saturating stall/flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int HOLD_W       = 3,
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int DRAIN_CYCLES = 2,
  parameter int PERF_W       = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      jump_flag_i,
  input  logic [ADDR_W-1:0]         jump_addr_i,
  input  logic [NUM_REQ-1:0]        hold_req_i,
  input  logic [NUM_REQ*HOLD_W-1:0] hold_lvl_i,
  input  logic                      halt_req_i,
  output logic                      halt_ack_o,
  output logic [HOLD_W-1:0]         hold_flag_o,
  output logic                      jump_flag_o,
  output logic [ADDR_W-1:0]         jump_addr_o,
  output logic [PERF_W-1:0]         stall_cnt_o,
  output logic [PERF_W-1:0]         flush_cnt_o
);

  localparam int FW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

  logic [FW-1:0]     r_bubble_cnt;
  logic [DW-1:0]     r_drain_cnt;
  state_t            r_state;
  logic              r_halt_ack;
  logic [HOLD_W-1:0] w_base;
  logic [HOLD_W-1:0] w_arb;

  assign w_base = (jump_flag_i || (r_bubble_cnt != '0) || (r_state != ST_RUN))
                  ? HOLD_W'(HOLD_ID) : HOLD_W'(HOLD_NONE);

  pipe_ctrl_hold_arb #(
    .NUM_REQ (NUM_REQ),
    .HOLD_W  (HOLD_W)
  ) u_hold_arb (
    .i_base (w_base),
    .i_req  (hold_req_i),
    .i_lvl  (hold_lvl_i),
    .o_lvl  (w_arb)
  );

  assign jump_flag_o = rst ? 1'b0 : jump_flag_i;
  assign jump_addr_o = jump_addr_i;
  assign hold_flag_o = rst ? HOLD_W'(HOLD_ID) : w_arb;
  assign halt_ack_o  = r_halt_ack;

  // A new jump reloads rather than extends the bubble window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_bubble_cnt <= '0;
    else if (jump_flag_i)
      r_bubble_cnt <= FW'(FLUSH_CYCLES);
    else if (r_bubble_cnt != '0)
      r_bubble_cnt <= r_bubble_cnt - FW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
      r_halt_ack  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (halt_req_i) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= DW'(DRAIN_CYCLES - 1);
          end
        end
        ST_DRAIN: begin
          if (!halt_req_i) begin
            r_state <= ST_RUN;
          end else if (jump_flag_i) begin
            r_drain_cnt <= DW'(DRAIN_CYCLES - 1);
          end else if (r_drain_cnt == '0) begin
            r_state    <= ST_HALTED;
            r_halt_ack <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - DW'(1);
          end
        end
        ST_HALTED: begin
          if (!halt_req_i) begin
            r_state    <= ST_RUN;
            r_halt_ack <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_RUN;
          r_halt_ack <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] r_stall_cnt;
  logic [PERF_W-1:0] r_jump_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_jump_cnt  <= '0;
    end else begin
      if ((w_arb != HOLD_W'(HOLD_NONE)) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + PERF_W'(1);
      if (jump_flag_i && (r_jump_cnt != '1))
        r_jump_cnt <= r_jump_cnt + PERF_W'(1);
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_jump_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
